// File: rtl/seg_disp_arb_if.sv
// Display arbiter bus: three requesters on one side, display driver on the other.
// master = requester/driver side, slave = arbiter side.
interface seg_disp_arb_if;
  logic [2:0]  req;
  logic [19:0] data0;
  logic [19:0] data1;
  logic [19:0] data2;
  logic [7:0]  point0;
  logic [7:0]  point1;
  logic [7:0]  point2;
  logic [2:0]  sign_in;
  logic [2:0]  gnt;
  logic [19:0] data;
  logic [7:0]  point;
  logic        sign;
  logic        seg_en;

  modport master (
    output req, data0, data1, data2, point0, point1, point2, sign_in,
    input  gnt, data, point, sign, seg_en
  );

  modport slave (
    input  req, data0, data1, data2, point0, point1, point2, sign_in,
    output gnt, data, point, sign, seg_en
  );
endinterface

// File: rtl/seg_disp_arb.sv
// Round-robin arbiter sharing one 6-digit 7-segment display among three
// requesters. An owner keeps the display for at least HOLD_MAX+1 clocks
// unless it drops its request; a one-cycle blank separates owners.
// Optional build macro: SEG_ARB_PREEMPT_EN (requester 0 preempts any other owner).
module seg_disp_arb #(
  parameter logic [25:0] HOLD_MAX = 26'd49_999_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  seg_disp_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [25:0] cnt_q, cnt_d;
  logic [2:0]  gnt_q, gnt_d;
  logic        seg_en_q, seg_en_d;
  logic [19:0] data_q, data_d;
  logic [7:0]  point_q, point_d;
  logic        sign_q, sign_d;
  logic [1:0]  rr_c1_s, rr_c2_s, rr_idx_s;
  logic [2:0]  others_s;
  logic        hold_done_s;
  logic        release_s;
`ifdef SEG_ARB_PREEMPT_EN
  logic        pre_q, pre_d;
`endif

  // Index following i in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    case (i)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Round-robin winner: search last+1, last+2, then last itself.
  always_comb begin
    rr_c1_s = rr_next(last_q);
    rr_c2_s = rr_next(rr_c1_s);
    if (bus.req[rr_c1_s]) begin
      rr_idx_s = rr_c1_s;
    end else if (bus.req[rr_c2_s]) begin
      rr_idx_s = rr_c2_s;
    end else begin
      rr_idx_s = last_q;
    end
  end

  // State register plus owner, round-robin pointer and hold counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 26'd0;
`ifdef SEG_ARB_PREEMPT_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef SEG_ARB_PREEMPT_EN
      pre_q   <= pre_d;
`endif
    end
  end

  // Next-state logic: grant, release and blank-gap sequencing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    others_s    = bus.req & ~onehot(owner_q);
    hold_done_s = (cnt_q == HOLD_MAX);
    release_s   = !bus.req[owner_q] || (hold_done_s && (|others_s));
`ifdef SEG_ARB_PREEMPT_EN
    pre_d       = 1'b0;
    if (bus.req[0] && (owner_q != 2'd0)) begin
      release_s = 1'b1;
    end else begin
      release_s = release_s;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d = S_OWN;
          owner_d = rr_idx_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (release_s) begin
          state_d = (|others_s) ? S_BLANK : S_IDLE;
          last_d  = owner_q;
`ifdef SEG_ARB_PREEMPT_EN
          pre_d   = bus.req[0] && (owner_q != 2'd0);
`endif
        end else begin
          state_d = S_OWN;
        end
      end
      S_BLANK: begin
        if (|bus.req) begin
          state_d = S_OWN;
          owner_d = rr_idx_s;
`ifdef SEG_ARB_PREEMPT_EN
          // A preempting requester 0 wins regardless of the pointer.
          if (pre_q && bus.req[0]) begin
            owner_d = 2'd0;
          end else begin
            owner_d = rr_idx_s;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered display outputs and counter.
  always_comb begin
    gnt_d    = (state_d == S_OWN) ? onehot(owner_d) : 3'b000;
    seg_en_d = (state_d == S_OWN);
    if ((state_d == S_OWN) && (state_q != S_OWN)) begin
      cnt_d = 26'd0;
    end else if ((state_q == S_OWN) && (cnt_q != HOLD_MAX)) begin
      cnt_d = cnt_q + 26'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (state_q == S_OWN) begin
      case (owner_q)
        2'd0: begin
          data_d  = bus.data0;
          point_d = bus.point0;
          sign_d  = bus.sign_in[0];
        end
        2'd1: begin
          data_d  = bus.data1;
          point_d = bus.point1;
          sign_d  = bus.sign_in[1];
        end
        default: begin
          data_d  = bus.data2;
          point_d = bus.point2;
          sign_d  = bus.sign_in[2];
        end
      endcase
    end else begin
      data_d  = data_q;
      point_d = point_q;
      sign_d  = sign_q;
    end
  end

  // Output registers feeding the display driver.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt_q    <= 3'b000;
      seg_en_q <= 1'b0;
      data_q   <= 20'd0;
      point_q  <= 8'd0;
      sign_q   <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      seg_en_q <= seg_en_d;
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.seg_en = seg_en_q;
  assign bus.data   = data_q;
  assign bus.point  = point_q;
  assign bus.sign   = sign_q;

endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed scoreboard bench for seg_disp_arb with HOLD_MAX = 9.
module tb_seg_disp_arb;

  logic sys_clk;
  logic sys_rst_n;

  seg_disp_arb_if bus ();

  seg_disp_arb #(.HOLD_MAX(26'd9)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [2:0]  gnt;
    logic        seg_en;
    bit          chk;
    logic [19:0] data;
    logic [7:0]  point;
    logic        sign;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

`ifdef SEG_ARB_PREEMPT_EN
  int rr_own[4] = '{0, 1, 0, 1};
  int rr_len[4] = '{10, 1, 10, 1};
`else
  int rr_own[4] = '{0, 1, 2, 0};
  int rr_len[4] = '{10, 10, 10, 10};
`endif

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [2:0] g, input logic en,
                      input bit chk, input logic [19:0] d, input logic [7:0] p,
                      input logic s);
    exp_t e;
    e.gnt = g; e.seg_en = en; e.chk = chk; e.data = d; e.point = p; e.sign = s;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_front();
    exp_t  e;
    string t;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: observed=0 entries required>=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (bus.gnt === e.gnt) else begin
        errors++;
        $error("FAIL %s gnt: observed=%b expected=%b", t, bus.gnt, e.gnt);
      end
      checks++;
      assert (bus.seg_en === e.seg_en) else begin
        errors++;
        $error("FAIL %s seg_en: observed=%b expected=%b", t, bus.seg_en, e.seg_en);
      end
      if (e.chk) begin
        checks++;
        assert (bus.data === e.data) else begin
          errors++;
          $error("FAIL %s data: observed=%0d expected=%0d", t, bus.data, e.data);
        end
        checks++;
        assert (bus.point === e.point) else begin
          errors++;
          $error("FAIL %s point: observed=%h expected=%h", t, bus.point, e.point);
        end
        checks++;
        assert (bus.sign === e.sign) else begin
          errors++;
          $error("FAIL %s sign: observed=%b expected=%b", t, bus.sign, e.sign);
        end
      end
    end
  endtask

  // Expect the given outputs after the next rising edge.
  task automatic step(input string tag, input logic [2:0] g, input logic en,
                      input bit chk, input logic [19:0] d, input logic [7:0] p,
                      input logic s);
    push(tag, g, en, chk, d, p, s);
    @(posedge sys_clk);
    #1;
    compare_front();
  endtask

  // Expect the given outputs right now (no clock edge).
  task automatic check_now(input string tag, input logic [2:0] g, input logic en,
                           input bit chk, input logic [19:0] d, input logic [7:0] p,
                           input logic s);
    push(tag, g, en, chk, d, p, s);
    compare_front();
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    bus.req     = 3'b000;
    bus.data0   = 20'd11111;
    bus.data1   = 20'd22222;
    bus.data2   = 20'd33333;
    bus.point0  = 8'h11;
    bus.point1  = 8'h22;
    bus.point2  = 8'h33;
    bus.sign_in = 3'b111;
    repeat (2) @(posedge sys_clk);
    #1;
    check_now("reset", 3'b000, 1'b0, 1'b1, 20'd0, 8'h00, 1'b0);
    sys_rst_n = 1'b1;
    step("idle", 3'b000, 1'b0, 1'b1, 20'd0, 8'h00, 1'b0);

    // First grant to requester 1; data follows one cycle after gnt.
    bus.req = 3'b010; bus.data1 = 20'd123456; bus.point1 = 8'hA5; bus.sign_in = 3'b010;
    step("grant1", 3'b010, 1'b1, 1'b1, 20'd0, 8'h00, 1'b0);
    step("data1", 3'b010, 1'b1, 1'b1, 20'd123456, 8'hA5, 1'b1);
    step("own1_c3", 3'b010, 1'b1, 1'b1, 20'd123456, 8'hA5, 1'b1);

    // Requester 2 waits until the hold expires; its data must not leak.
    bus.req = 3'b110; bus.data2 = 20'd777; bus.point2 = 8'h3C; bus.sign_in = 3'b110;
    for (int k = 4; k <= 10; k++)
      step("own1_hold", 3'b010, 1'b1, 1'b1, 20'd123456, 8'hA5, 1'b1);
    step("blank12", 3'b000, 1'b0, 1'b1, 20'd123456, 8'hA5, 1'b1);
    step("grant2", 3'b100, 1'b1, 1'b1, 20'd123456, 8'hA5, 1'b1);
    bus.req = 3'b100;
    step("data2", 3'b100, 1'b1, 1'b1, 20'd777, 8'h3C, 1'b1);
    step("own2_c3", 3'b100, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
    step("own2_c4", 3'b100, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);

    // Owner 2 drops with nobody waiting: straight to idle, data held.
    bus.req = 3'b000; bus.data2 = 20'd888;
    step("drop2_idle", 3'b000, 1'b0, 1'b1, 20'd888, 8'h3C, 1'b1);
    bus.data2 = 20'd999;
    step("idle_hold", 3'b000, 1'b0, 1'b1, 20'd888, 8'h3C, 1'b1);

    // Reset pulse in the middle of an ownership.
    bus.req = 3'b001; bus.data0 = 20'd4242; bus.point0 = 8'h0F; bus.sign_in = 3'b000;
    step("grant0", 3'b001, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
    step("data0", 3'b001, 1'b1, 1'b1, 20'd4242, 8'h0F, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check_now("async_rst", 3'b000, 1'b0, 1'b1, 20'd0, 8'h00, 1'b0);
    bus.req = 3'b110;
    #2;
    sys_rst_n = 1'b1;
    step("post_rst_grant", 3'b010, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
    bus.req = 3'b000;
    step("post_rst_idle", 3'b000, 1'b0, 1'b0, 20'd0, 8'h00, 1'b0);

    // All three requesting from reset: rotation with blank gaps.
    sys_rst_n = 1'b0;
    bus.req = 3'b111;
    #2;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < rr_len[i]; k++)
        step("rr_own", 3'(3'b001 << rr_own[i]), 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
      step("rr_blank", 3'b000, 1'b0, 1'b0, 20'd0, 8'h00, 1'b0);
    end

    // Requester 0 arrives while owner 1 is early in its hold.
    sys_rst_n = 1'b0;
    bus.req = 3'b010;
    #2;
    sys_rst_n = 1'b1;
    step("p_grant1", 3'b010, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
    step("p_own1_c2", 3'b010, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
    bus.req = 3'b011;
`ifndef SEG_ARB_PREEMPT_EN
    for (int k = 3; k <= 10; k++)
      step("np_own1_hold", 3'b010, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);
`endif
    step("p_blank", 3'b000, 1'b0, 1'b0, 20'd0, 8'h00, 1'b0);
    step("p_grant0", 3'b001, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);

    // Sole requester past saturation keeps the display indefinitely.
    bus.req = 3'b001;
    for (int k = 0; k < 20; k++)
      step("sat_own0", 3'b001, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);

    // Saturated hold with a new request releases at once.
    bus.req = 3'b011;
    step("sat_blank", 3'b000, 1'b0, 1'b0, 20'd0, 8'h00, 1'b0);
    step("sat_grant1", 3'b010, 1'b1, 1'b0, 20'd0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_disp_arb.md
SEG_DISP_ARB -- requirements
Module: seg_disp_arb

Interface
REQ-001 Parameter: HOLD_MAX, 26'd49_999_999, minimum ownership time in clocks minus 1 (1 s at 50 MHz).
REQ-002 sys_clk  input  1  system clock, 50 MHz; only clock.
REQ-003 sys_rst_n  input  1  asynchronous reset, active low.
REQ-004 req  input  3  display request per requester; level, bit i = requester i.
REQ-005 data0/data1/data2  input  20  value to display per requester, 0..999_999.
REQ-006 point0/point1/point2  input  8  decimal-point pattern per requester, high = lit.
REQ-007 sign_in  input  3  negative-sign flag per requester.
REQ-008 gnt  output  3  one-hot current owner; all zero when no owner.
REQ-009 data  output  20  value to the 6-digit display driver.
REQ-010 point  output  8  decimal points to the display driver.
REQ-011 sign  output  1  sign to the display driver, high = minus.
REQ-012 seg_en  output  1  display enable, high = on.

Function
REQ-013 FSM states: IDLE (no owner), OWN (one owner), BLANK (one-cycle gap between owners); all outputs are registered.
REQ-014 IDLE: gnt=0, seg_en=0, data/point/sign hold their last values; if any req bit is high in cycle N, go to OWN with the round-robin winner, and gnt and seg_en are high from cycle N+1.
REQ-015 Round-robin: search order is last_owner+1, last_owner+2, last_owner (mod 3); the first requester found with req high wins.
REQ-016 OWN: every cycle, data/point/sign are loaded from the owner's inputs (1-cycle latency); seg_en=1; gnt=owner.
REQ-017 Hold counter (26 bit) clears to 0 on every grant, increments each OWN cycle and saturates at HOLD_MAX; hold_done = (count == HOLD_MAX).
REQ-018 Release from OWN occurs when (a) the owner's req drops, regardless of hold_done, or (b) hold_done and any other req bit is high.
REQ-019 On release, the next state is BLANK if any non-owner req is high, otherwise IDLE; last_owner is updated to the releasing owner.
REQ-020 BLANK lasts exactly 1 cycle: gnt=0, seg_en=0, data held; arbitration uses the req value of that cycle; a winner goes to OWN, no request goes to IDLE.
REQ-021 If the owner drops req in the same cycle that hold_done and other requests are pending, the release is cause (a); the result is the same path to BLANK.
REQ-022 In OWN with hold_done and only the owner requesting, ownership continues indefinitely and the counter stays saturated.
REQ-023 Input changes on non-owner data/point/sign have no effect on the outputs.

Reset
REQ-024 While sys_rst_n=0: state=IDLE, gnt=0, data=0, point=0, sign=0, seg_en=0, hold counter=0, last_owner=2 (requester 0 is searched first).
REQ-025 Reset asserted mid-OWN or mid-BLANK takes effect immediately (asynchronously); after release, arbitration restarts from IDLE with no memory of the prior owner.

Configuration
REQ-026 Macro SEG_ARB_PREEMPT_EN defined: in OWN, if req[0] is high and the owner is not 0, release immediately (ignore hold_done), pass through BLANK, and grant requester 0 regardless of the round-robin pointer.
REQ-027 SEG_ARB_PREEMPT_EN undefined: requester 0 is an ordinary round-robin participant, and the ports are identical in both builds.

Verification (HOLD_MAX=9 for all scenarios)
REQ-028 Reset, then req=3'b010 with data1=20'd123456 at cycle N -> gnt=3'b010, seg_en=1 at N+1; data=123456 at N+2.
REQ-029 Owner 1 holds; req[2] rises at OWN cycle 3 -> owner keeps gnt until count=9, then 1 BLANK cycle (seg_en=0), then gnt=3'b100.
REQ-030 req=3'b111 from reset -> grant order 0, 1, 2, 0, each ownership lasting 10 OWN cycles plus 1 BLANK cycle.
REQ-031 Owner 2 drops req at OWN cycle 4 with no other requests -> IDLE next cycle, seg_en=0, gnt=0, data holds the last value of data2.
REQ-032 With SEG_ARB_PREEMPT_EN: owner 1 at cycle 2, req[0] rises -> BLANK next cycle, then gnt=3'b001; without the macro, owner 1 keeps gnt to count=9.
REQ-033 sys_rst_n pulsed low during OWN -> all outputs are 0 within the same cycle; after release with req=3'b110, requester 1 is granted first.
